// File: rtl/gps_correlator_channel.sv
// Single-channel GPS correlator: carrier NCO wipe-off, C/A despreading, and prompt I/Q
// integrate-and-dump over one full code period. Optional macro CORR_SATURATE_EN: saturating accumulators.
module gps_correlator_channel #(
  parameter int unsigned ACC_W     = 24,
  parameter logic [31:0] CODE_STEP = 32'd1098437886
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic                    sample_valid,
  input  logic signed [7:0]       real_in,
  input  logic signed [7:0]       imag_in,
  input  logic        [31:0]      freq,
  input  logic        [5:0]       ca_sel,
  output logic                    code_chip,
  output logic        [9:0]       chip_idx,
  output logic                    busy,
  output logic                    dump_valid,
  output logic signed [ACC_W-1:0] dump_i,
  output logic signed [ACC_W-1:0] dump_q
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e state_q, state_d;
  logic do_start, do_sample;

  logic [5:0]       prn_q;
  logic [9:0]       g1_q, g2_q, idx_q;
  logic [31:0]      code_ph_q, car_ph_q;
  logic [ACC_W-1:0] acc_i_q, acc_q_q, acc_i_d, acc_q_d;
  logic             dump_valid_q;
  logic [ACC_W-1:0] dump_i_q, dump_q_q;

  logic [9:0]        tap_mask;
  logic              chip;
  logic [32:0]       code_sum;
  logic              carry, last;
  logic signed [8:0] r9, i9, rot_i, rot_q, prod_i, prod_q;
  logic [ACC_W-1:0]  prod_i_ext, prod_q_ext;

  // Two G2 stages (1-based) per PRN select the output taps.
  function automatic logic [9:0] taps(input int unsigned a, input int unsigned b);
    taps = (10'd1 << (a - 1)) | (10'd1 << (b - 1));
  endfunction

  always_comb begin
    case (prn_q)
      6'd0:  tap_mask = taps(2, 6);   6'd1:  tap_mask = taps(3, 7);
      6'd2:  tap_mask = taps(4, 8);   6'd3:  tap_mask = taps(5, 9);
      6'd4:  tap_mask = taps(1, 9);   6'd5:  tap_mask = taps(2, 10);
      6'd6:  tap_mask = taps(1, 8);   6'd7:  tap_mask = taps(2, 9);
      6'd8:  tap_mask = taps(3, 10);  6'd9:  tap_mask = taps(2, 3);
      6'd10: tap_mask = taps(3, 4);   6'd11: tap_mask = taps(5, 6);
      6'd12: tap_mask = taps(6, 7);   6'd13: tap_mask = taps(7, 8);
      6'd14: tap_mask = taps(8, 9);   6'd15: tap_mask = taps(9, 10);
      6'd16: tap_mask = taps(1, 4);   6'd17: tap_mask = taps(2, 5);
      6'd18: tap_mask = taps(3, 6);   6'd19: tap_mask = taps(4, 7);
      6'd20: tap_mask = taps(5, 8);   6'd21: tap_mask = taps(6, 9);
      6'd22: tap_mask = taps(1, 3);   6'd23: tap_mask = taps(4, 6);
      6'd24: tap_mask = taps(5, 7);   6'd25: tap_mask = taps(6, 8);
      6'd26: tap_mask = taps(7, 9);   6'd27: tap_mask = taps(8, 10);
      6'd28: tap_mask = taps(1, 6);   6'd29: tap_mask = taps(2, 7);
      6'd30: tap_mask = taps(3, 8);   6'd31: tap_mask = taps(4, 9);
      6'd32: tap_mask = taps(5, 10);  6'd33: tap_mask = taps(4, 10);
      6'd34: tap_mask = taps(1, 7);   6'd35: tap_mask = taps(2, 8);
      default: tap_mask = taps(2, 6);
    endcase
  end

  // g*_q[0] is stage 1, g*_q[9] is stage 10.
  assign chip     = g1_q[9] ^ (^(g2_q & tap_mask));
  assign code_sum = {1'b0, code_ph_q} + {1'b0, CODE_STEP};
  assign carry    = code_sum[32];
  assign last     = carry && (idx_q == 10'd1022);

  always_comb begin
    r9 = {real_in[7], real_in};
    i9 = {imag_in[7], imag_in};
    case (car_ph_q[31:30])
      2'd0:    begin rot_i = r9;  rot_q = i9;  end
      2'd1:    begin rot_i = i9;  rot_q = -r9; end
      2'd2:    begin rot_i = -r9; rot_q = -i9; end
      default: begin rot_i = -i9; rot_q = r9;  end
    endcase
    prod_i     = chip ? -rot_i : rot_i;
    prod_q     = chip ? -rot_q : rot_q;
    prod_i_ext = {{(ACC_W - 9){prod_i[8]}}, prod_i};
    prod_q_ext = {{(ACC_W - 9){prod_q[8]}}, prod_q};
  end

`ifdef CORR_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};
  logic             sat_i_q, sat_q_q, sat_i_d, sat_q_d;
  logic [ACC_W:0]   wide_i, wide_q;

  // Once clipped, an accumulator holds its rail until the period ends.
  always_comb begin
    wide_i  = {acc_i_q[ACC_W-1], acc_i_q} + {prod_i_ext[ACC_W-1], prod_i_ext};
    wide_q  = {acc_q_q[ACC_W-1], acc_q_q} + {prod_q_ext[ACC_W-1], prod_q_ext};
    sat_i_d = sat_i_q;
    sat_q_d = sat_q_q;
    acc_i_d = wide_i[ACC_W-1:0];
    acc_q_d = wide_q[ACC_W-1:0];
    if (sat_i_q) begin
      acc_i_d = acc_i_q;
    end else if (wide_i[ACC_W] != wide_i[ACC_W-1]) begin
      sat_i_d = 1'b1;
      acc_i_d = wide_i[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    if (sat_q_q) begin
      acc_q_d = acc_q_q;
    end else if (wide_q[ACC_W] != wide_q[ACC_W-1]) begin
      sat_q_d = 1'b1;
      acc_q_d = wide_q[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  always_comb begin
    acc_i_d = acc_i_q + prod_i_ext;
    acc_q_d = acc_q_q + prod_q_ext;
  end
`endif

  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    do_sample = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable && start) begin
          state_d  = StRun;
          do_start = 1'b1;
        end
      end
      StRun: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (start) begin
          do_start = 1'b1;
        end else if (sample_valid) begin
          do_sample = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prn_q        <= '0;
      g1_q         <= 10'h3FF;
      g2_q         <= 10'h3FF;
      idx_q        <= '0;
      code_ph_q    <= '0;
      car_ph_q     <= '0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      dump_valid_q <= 1'b0;
      dump_i_q     <= '0;
      dump_q_q     <= '0;
`ifdef CORR_SATURATE_EN
      sat_i_q      <= 1'b0;
      sat_q_q      <= 1'b0;
`endif
    end else begin
      dump_valid_q <= 1'b0;
      if (do_start) begin
        prn_q     <= ca_sel;
        g1_q      <= 10'h3FF;
        g2_q      <= 10'h3FF;
        idx_q     <= '0;
        code_ph_q <= '0;
        car_ph_q  <= '0;
        acc_i_q   <= '0;
        acc_q_q   <= '0;
`ifdef CORR_SATURATE_EN
        sat_i_q   <= 1'b0;
        sat_q_q   <= 1'b0;
`endif
      end else if (do_sample) begin
        car_ph_q  <= car_ph_q + freq;
        code_ph_q <= code_sum[31:0];
        if (carry) begin
          if (last) begin
            idx_q <= '0;
            g1_q  <= 10'h3FF;
            g2_q  <= 10'h3FF;
          end else begin
            idx_q <= idx_q + 10'd1;
            g1_q  <= {g1_q[8:0], g1_q[2] ^ g1_q[9]};
            g2_q  <= {g2_q[8:0], g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9]};
          end
        end
        if (last) begin
          dump_valid_q <= 1'b1;
          dump_i_q     <= acc_i_d;
          dump_q_q     <= acc_q_d;
          acc_i_q      <= '0;
          acc_q_q      <= '0;
`ifdef CORR_SATURATE_EN
          sat_i_q      <= 1'b0;
          sat_q_q      <= 1'b0;
`endif
        end else begin
          acc_i_q <= acc_i_d;
          acc_q_q <= acc_q_d;
`ifdef CORR_SATURATE_EN
          sat_i_q <= sat_i_d;
          sat_q_q <= sat_q_d;
`endif
        end
      end
    end
  end

  assign busy       = (state_q == StRun);
  assign code_chip  = busy & chip;
  assign chip_idx   = idx_q;
  assign dump_valid = dump_valid_q;
  assign dump_i     = dump_i_q;
  assign dump_q     = dump_q_q;

endmodule

// File: tb/tb_gps_correlator_channel.sv
// Randomized bench for gps_correlator_channel against a sample-count based reference model.
module tb_gps_correlator_channel;

  localparam int unsigned ACC_W     = 12;
  localparam logic [31:0] CODE_STEP = 32'h8000_0000;
  localparam longint unsigned STEP  = 64'h8000_0000;
  localparam longint MODV    = longint'(1) << ACC_W;
  localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));
`ifdef CORR_SATURATE_EN
  localparam longint SAT_EXP = 2047;
`else
  localparam longint SAT_EXP = 1794;
`endif

  logic                    clk, reset, enable, start, sample_valid;
  logic signed [7:0]       real_in, imag_in;
  logic        [31:0]      freq;
  logic        [5:0]       ca_sel;
  logic                    code_chip, busy, dump_valid;
  logic        [9:0]       chip_idx;
  logic signed [ACC_W-1:0] dump_i, dump_q;

  gps_correlator_channel #(.ACC_W(ACC_W), .CODE_STEP(CODE_STEP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .sample_valid(sample_valid), .real_in(real_in), .imag_in(imag_in), .freq(freq),
    .ca_sel(ca_sel), .code_chip(code_chip), .chip_idx(chip_idx), .busy(busy),
    .dump_valid(dump_valid), .dump_i(dump_i), .dump_q(dump_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // G2 stage pairs (1-based) for PRN 1..36.
  int tap_a [36] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4,5,4,1,2};
  int tap_b [36] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9,10,10,7,8};
  bit code_tab [36][1023];

  task automatic build_codes();
    bit g1 [1:10];
    bit g2 [1:10];
    bit f1, f2;
    for (int p = 0; p < 36; p++) begin
      for (int j = 1; j <= 10; j++) begin g1[j] = 1'b1; g2[j] = 1'b1; end
      for (int k = 0; k < 1023; k++) begin
        code_tab[p][k] = g1[10] ^ g2[tap_a[p]] ^ g2[tap_b[p]];
        f1 = g1[3] ^ g1[10];
        f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
        for (int j = 10; j >= 2; j--) begin g1[j] = g1[j-1]; g2[j] = g2[j-1]; end
        g1[1] = f1;
        g2[1] = f2;
      end
    end
  endtask

  // Model: chip count is floor(n*STEP/2^32) after n valid samples since start.
  bit              m_run, m_dv, m_si, m_sq;
  int              m_prn;
  longint unsigned m_n;
  logic [31:0]     m_car;
  longint          m_ai, m_aq, m_di, m_dq;

  function automatic longint unsigned cnt(input longint unsigned n);
    return (n * STEP) >> 32;
  endfunction

  function automatic longint wrapn(input longint x);
    longint m;
    m = x & (MODV - 1);
    if (m > ACC_MAX) m -= MODV;
    return m;
  endfunction

  task automatic model_reset();
    m_run = 0; m_dv = 0; m_si = 0; m_sq = 0; m_prn = 0; m_n = 0; m_car = '0;
    m_ai = 0; m_aq = 0; m_di = 0; m_dq = 0;
  endtask

  task automatic model_start(input int sel);
    m_run = 1; m_prn = sel; m_n = 0; m_car = '0;
    m_ai = 0; m_aq = 0; m_si = 0; m_sq = 0;
  endtask

  task automatic acc_step(inout longint a, inout bit s, input longint p);
`ifdef CORR_SATURATE_EN
    if (!s) begin
      a = a + p;
      if (a > ACC_MAX) begin a = ACC_MAX; s = 1; end
      else if (a < ACC_MIN) begin a = ACC_MIN; s = 1; end
    end
`else
    a = wrapn(a + p);
    s = 0;
`endif
  endtask

  task automatic model_sample(input longint r, input longint im, input logic [31:0] f);
    longint unsigned c0, c1;
    longint pi, pq;
    bit ch;
    c0 = cnt(m_n);
    c1 = cnt(m_n + 1);
    ch = code_tab[m_prn][int'(c0 % 1023)];
    case (m_car[31:30])
      2'd0: begin pi = r;   pq = im;  end
      2'd1: begin pi = im;  pq = -r;  end
      2'd2: begin pi = -r;  pq = -im; end
      default: begin pi = -im; pq = r; end
    endcase
    if (ch) begin pi = -pi; pq = -pq; end
    acc_step(m_ai, m_si, pi);
    acc_step(m_aq, m_sq, pq);
    m_car = m_car + f;
    m_n++;
    if (c1 != c0 && (c1 % 1023) == 0) begin
      m_dv = 1; m_di = m_ai; m_dq = m_aq;
      m_ai = 0; m_aq = 0; m_si = 0; m_sq = 0;
    end
  endtask

  task automatic check_outputs();
    int idx;
    check("busy", busy, longint'(m_run));
    check("dump_valid", dump_valid, longint'(m_dv));
    check("dump_i", dump_i, m_di);
    check("dump_q", dump_q, m_dq);
    if (m_run) begin
      idx = int'(cnt(m_n) % 1023);
      check("chip_idx", chip_idx, idx);
      check("code_chip", code_chip, longint'(code_tab[m_prn][idx]));
    end else begin
      check("code_chip_idle", code_chip, 0);
    end
  endtask

  // One clock: drive inputs, advance the model, then sample 1ns after the edge.
  task automatic cycle(input bit en, input bit st, input bit sv, input logic signed [7:0] r,
                       input logic signed [7:0] im, input logic [31:0] f, input logic [5:0] sel);
    enable = en; start = st; sample_valid = sv; real_in = r; imag_in = im; freq = f;
    ca_sel = sel;
    m_dv = 0;
    if (!m_run) begin
      if (en && st) model_start(int'(sel));
    end else if (!en) begin
      m_run = 0;
    end else if (st) begin
      model_start(int'(sel));
    end else if (sv) begin
      model_sample(longint'(r), longint'(im), f);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Start PRN1 and stream until the first dump; sat_mode drives +/-127 matched to the code.
  task automatic run_until_dump(input bit sat_mode, input logic signed [7:0] r,
                                input logic signed [7:0] im, input logic [31:0] f,
                                output int n);
    logic signed [7:0] re;
    n = 0;
    cycle(1, 1, 1, r, im, f, 6'd0);
    for (int c = 0; c < 5000; c++) begin
      re = r;
      if (sat_mode) re = code_tab[m_prn][int'(cnt(m_n) % 1023)] ? -8'sd127 : 8'sd127;
      cycle(1, 0, 1, re, im, f, 6'd0);
      n++;
      if (dump_valid) break;
    end
  endtask

  initial begin
    logic [9:0] prn1_pat;
    int n;
    prn1_pat = 10'b1100100000;
    build_codes();
    model_reset();
    reset = 1; enable = 0; start = 0; sample_valid = 0;
    real_in = '0; imag_in = '0; freq = '0; ca_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_dump_i", dump_i, 0);
    check("rst_dump_q", dump_q, 0);
    check("rst_chip_idx", chip_idx, 0);
    check("rst_code_chip", code_chip, 0);
    reset = 0;

    // PRN1 code start; the sample arriving with start is dropped.
    cycle(1, 1, 1, 8'sd50, 8'sd0, 32'd0, 6'd0);
    for (int k = 0; k < 10; k++) begin
      check("prn1_chip", code_chip, longint'(prn1_pat[9-k]));
      cycle(1, 0, 1, 8'sd0, 8'sd0, 32'd0, 6'd0);
      cycle(1, 0, 1, 8'sd0, 8'sd0, 32'd0, 6'd0);
    end

    run_until_dump(0, 8'sd10, 8'sd0, 32'd0, n);
    check("const_period", n, 2046);
    check("const_dump_i", dump_i, -20);
    check("const_dump_q", dump_q, 0);

    run_until_dump(0, 8'sd0, 8'sd10, 32'd0, n);
    check("rot_period", n, 2046);
    check("rot_dump_i", dump_i, 0);
    check("rot_dump_q", dump_q, -20);

    run_until_dump(0, 8'sd10, 8'sd0, 32'h4000_0000, n);
    check("quad_period", n, 2046);

    run_until_dump(1, 8'sd0, 8'sd0, 32'd0, n);
    check("sat_dump_i", dump_i, SAT_EXP);
    check("sat_dump_q", dump_q, 0);

    // Abort by enable: no dump, outputs hold, stays idle without a new start.
    cycle(1, 1, 0, 8'sd0, 8'sd0, 32'd0, 6'd4);
    for (int c = 0; c < 100; c++) cycle(1, 0, 1, 8'($urandom), 8'($urandom), $urandom, 6'd0);
    cycle(0, 0, 1, 8'sd1, 8'sd1, 32'd0, 6'd0);
    check("abort_busy", busy, 0);
    for (int c = 0; c < 40; c++) cycle(1, 0, 1, 8'($urandom), 8'($urandom), $urandom, 6'd0);
    cycle(0, 1, 1, 8'sd1, 8'sd1, 32'd0, 6'd3);
    check("start_no_enable", busy, 0);

    // Asynchronous reset mid-run.
    cycle(1, 1, 0, 8'sd0, 8'sd0, 32'd0, 6'd7);
    for (int c = 0; c < 60; c++) cycle(1, 0, 1, 8'($urandom), 8'($urandom), $urandom, 6'd0);
    #2 reset = 1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_dump_i", dump_i, 0);
    check("arst_dump_q", dump_q, 0);
    check("arst_chip_idx", chip_idx, 0);
    check("arst_code_chip", code_chip, 0);
    check("arst_dump_valid", dump_valid, 0);
    @(posedge clk);
    #2 reset = 0;
    model_reset();
    for (int c = 0; c < 20; c++) cycle(1, 0, 1, 8'($urandom), 8'($urandom), $urandom, 6'd0);

    // Random episodes: gaps in sample_valid, random Doppler, rare aborts and restarts.
    for (int e = 0; e < 5; e++) begin
      cycle(1, 1, 1, 8'($urandom), 8'($urandom), $urandom, 6'($urandom_range(0, 35)));
      for (int c = 0; c < 3500; c++) begin
        bit en, st, sv;
        en = ($urandom % 4000) != 0;
        st = m_run ? (($urandom % 5000) == 0) : (($urandom % 8) == 0);
        sv = ($urandom % 4) != 0;
        cycle(en, st, sv, 8'($urandom), 8'($urandom), $urandom, 6'($urandom_range(0, 35)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
